// File: rtl/gpio_pad_chain.sv
// gpio_pad_chain
// Pad-side responder for the GPIO pad daisy chain. All chain pins are
// sampled through two-flop synchronizers into the mclk domain. A complete
// configuration frame is committed to pad_cfg on a load strobe, and the
// pad input levels are returned on the serial output.
module gpio_pad_chain #(
  parameter int NPAD = 8,
  parameter int CFGW = 4,
  parameter logic [NPAD*CFGW-1:0] CFG_RST = {(NPAD*CFGW){1'b0}}
) (
  input  logic                 mclk,
  input  logic                 h_reset_n,
  input  logic                 shift_rstn,
  input  logic                 shift_clock,
  input  logic                 shift_load,
  input  logic                 shift_data_in,
  output logic                 shift_data_out,
  input  logic [NPAD-1:0]      pad_in,
  output logic [NPAD*CFGW-1:0] pad_cfg,
  output logic                 cfg_valid,
  output logic                 frame_err
);

  localparam int TOT = NPAD * CFGW;
  localparam int CW  = $clog2(TOT + 2);
  // A full frame, and the saturation value that marks an overlong frame.
  localparam logic [CW-1:0] CNT_FULL = CW'(TOT);
  localparam logic [CW-1:0] CNT_SAT  = CW'(TOT + 1);

  // Synchronizer bit positions: {rstn, clock, load, data}.
  localparam int S_RSTN = 3;
  localparam int S_CLK  = 2;
  localparam int S_LOAD = 1;
  localparam int S_DIN  = 0;

  logic [3:0]     sync1_d, sync1_q;
  logic [3:0]     sync2_d, sync2_q;
  // Third stage for edge detection: {clock, load}.
  logic [1:0]     prev_d, prev_q;

  logic [TOT-1:0] shift_reg_d, shift_reg_q;
  logic [CW-1:0]  bit_cnt_d, bit_cnt_q;
  logic [TOT-1:0] pad_cfg_d, pad_cfg_q;
  logic           cfg_valid_d, cfg_valid_q;
  logic           frame_err_d, frame_err_q;
  logic           sdo_d, sdo_q;

  logic           chain_run_s;
  logic           shift_rise_s;
  logic           load_rise_s;

  assign chain_run_s  = sync2_q[S_RSTN];
  assign shift_rise_s = sync2_q[S_CLK]  & ~prev_q[1];
  assign load_rise_s  = sync2_q[S_LOAD] & ~prev_q[0];

  // Synchronizer pipeline and serial-out next values.
  always_comb begin
    sync1_d = {shift_rstn, shift_clock, shift_load, shift_data_in};
    sync2_d = sync1_q;
    prev_d  = {sync2_q[S_CLK], sync2_q[S_LOAD]};
    sdo_d   = shift_reg_q[TOT-1];
  end

  // Frame engine: chain reset beats load, load beats shift.
  always_comb begin
    shift_reg_d = shift_reg_q;
    bit_cnt_d   = bit_cnt_q;
    pad_cfg_d   = pad_cfg_q;
    cfg_valid_d = cfg_valid_q;
    frame_err_d = frame_err_q;
    if (!chain_run_s) begin
      shift_reg_d = {TOT{1'b0}};
      bit_cnt_d   = {CW{1'b0}};
    end else if (load_rise_s) begin
      if (bit_cnt_q == CNT_FULL) begin
        pad_cfg_d   = shift_reg_q;
        cfg_valid_d = 1'b1;
        frame_err_d = 1'b0;
      end else begin
        frame_err_d = 1'b1;
      end
      // Status frame goes out MSB first, so pad_in[NPAD-1] leads.
      shift_reg_d = {pad_in, {(TOT-NPAD){1'b0}}};
      bit_cnt_d   = {CW{1'b0}};
    end else if (shift_rise_s) begin
      shift_reg_d = {shift_reg_q[TOT-2:0], sync2_q[S_DIN]};
      if (bit_cnt_q != CNT_SAT) begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end else begin
        bit_cnt_d = bit_cnt_q;
      end
    end else begin
      shift_reg_d = shift_reg_q;
    end
  end

  // State registers; the rstn synchronizer resets low so the chain starts held.
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      sync1_q     <= 4'b0000;
      sync2_q     <= 4'b0000;
      prev_q      <= 2'b00;
      shift_reg_q <= {TOT{1'b0}};
      bit_cnt_q   <= {CW{1'b0}};
      pad_cfg_q   <= CFG_RST;
      cfg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      sdo_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      shift_reg_q <= shift_reg_d;
      bit_cnt_q   <= bit_cnt_d;
      pad_cfg_q   <= pad_cfg_d;
      cfg_valid_q <= cfg_valid_d;
      frame_err_q <= frame_err_d;
      sdo_q       <= sdo_d;
    end
  end

  assign shift_data_out = sdo_q;
  assign pad_cfg        = pad_cfg_q;
  assign cfg_valid      = cfg_valid_q;
  assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_gpio_pad_chain.sv
// Testbench for gpio_pad_chain: drives the chain pins slowly relative to
// mclk and checks committed config, flags and the returned status stream.
module tb_gpio_pad_chain;

  localparam int NPAD = 8;
  localparam int CFGW = 4;
  localparam int TOT  = NPAD * CFGW;

  logic            mclk;
  logic            h_reset_n;
  logic            shift_rstn;
  logic            shift_clock;
  logic            shift_load;
  logic            shift_data_in;
  logic            shift_data_out;
  logic [NPAD-1:0] pad_in;
  logic [TOT-1:0]  pad_cfg;
  logic            cfg_valid;
  logic            frame_err;

  gpio_pad_chain #(.NPAD(NPAD), .CFGW(CFGW)) dut (
    .mclk           (mclk),
    .h_reset_n      (h_reset_n),
    .shift_rstn     (shift_rstn),
    .shift_clock    (shift_clock),
    .shift_load     (shift_load),
    .shift_data_in  (shift_data_in),
    .shift_data_out (shift_data_out),
    .pad_in         (pad_in),
    .pad_cfg        (pad_cfg),
    .cfg_valid      (cfg_valid),
    .frame_err      (frame_err)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side frame model
  int              bench_cnt = 0;
  logic [TOT-1:0]  exp_shift = '0;
  logic [TOT-1:0]  exp_cfg   = '0;
  logic            exp_valid = 1'b0;
  logic            exp_err   = 1'b0;

  // Scoreboards: expected serial-out bits and expected committed configs.
  logic            sdo_q[$];
  logic [TOT-1:0]  cfg_q[$];

  task automatic wait_clk(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  // One serial bit; checks the bit currently presented on shift_data_out.
  task automatic shift_bit(input logic b);
    logic e;
    if (sdo_q.size() > 0) begin
      e = sdo_q.pop_front();
      if (shift_data_out !== e) begin
        $display("FAIL sdo_bit: got %0b expected %0b", shift_data_out, e);
        n_fail++;
      end
      n_checks++;
    end
    shift_data_in = b;
    wait_clk(4);
    shift_clock = 1'b1;
    wait_clk(4);
    shift_clock = 1'b0;
    wait_clk(4);
    exp_shift = {exp_shift[TOT-2:0], b};
    if (bench_cnt < TOT + 1) bench_cnt++;
  endtask

  task automatic shift_word(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) shift_bit(w[31 - (i % 32)]);
  endtask

  // Load strobe; with both=1 the shift clock rises in the same instant.
  task automatic do_load(input logic both);
    logic [TOT-1:0] e;
    if (bench_cnt == TOT) begin
      exp_cfg   = exp_shift;
      exp_valid = 1'b1;
      exp_err   = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
    cfg_q.push_back(exp_cfg);
    shift_load = 1'b1;
    if (both) shift_clock = 1'b1;
    wait_clk(4);
    shift_load  = 1'b0;
    shift_clock = 1'b0;
    wait_clk(4);
    sdo_q.delete();
    for (int i = NPAD - 1; i >= 0; i--) sdo_q.push_back(pad_in[i]);
    for (int i = 0; i < TOT - NPAD; i++) sdo_q.push_back(1'b0);
    exp_shift = {pad_in, {(TOT-NPAD){1'b0}}};
    bench_cnt = 0;
    e = cfg_q.pop_front();
    if (pad_cfg !== e) begin
      $display("FAIL load_cfg: got %h expected %h", pad_cfg, e);
      n_fail++;
    end
    n_checks++;
    if (frame_err !== exp_err) begin
      $display("FAIL load_err: got %0b expected %0b", frame_err, exp_err);
      n_fail++;
    end
    n_checks++;
    if (cfg_valid !== exp_valid) begin
      $display("FAIL load_valid: got %0b expected %0b", cfg_valid, exp_valid);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_reset();
    h_reset_n = 1'b0; shift_rstn = 1'b0; shift_clock = 1'b0;
    shift_load = 1'b0; shift_data_in = 1'b0; pad_in = 8'h3C;
    wait_clk(3);
    if (pad_cfg !== 32'h0000_0000 || cfg_valid !== 1'b0 || frame_err !== 1'b0 ||
        shift_data_out !== 1'b0) begin
      $display("FAIL reset_state: got cfg=%h v=%0b e=%0b so=%0b expected 0/0/0/0",
               pad_cfg, cfg_valid, frame_err, shift_data_out);
      n_fail++;
    end
    n_checks++;
    h_reset_n = 1'b1;
    wait_clk(2);
    shift_rstn = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_commit();
    shift_word(32'hA5C3_1E7F, 32);
    do_load(1'b0);
    if (pad_cfg !== 32'hA5C3_1E7F || cfg_valid !== 1'b1 || frame_err !== 1'b0) begin
      $display("FAIL commit_frame: got cfg=%h v=%0b e=%0b expected a5c31e7f/1/0",
               pad_cfg, cfg_valid, frame_err);
      n_fail++;
    end
    n_checks++;
    if (pad_cfg[0 +: CFGW] !== 4'hF) begin
      $display("FAIL pad0_field: got %h expected f", pad_cfg[0 +: CFGW]);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_status_out();
    pad_in = 8'h96;
    wait_clk(2);
    do_load(1'b0);
    shift_word(32'h0000_0000, 8);
  endtask

  task automatic test_bad_length();
    shift_word(32'h1111_2222, 31);
    do_load(1'b0);
    if (frame_err !== 1'b1 || pad_cfg !== 32'hA5C3_1E7F) begin
      $display("FAIL short_frame: got e=%0b cfg=%h expected 1/a5c31e7f", frame_err, pad_cfg);
      n_fail++;
    end
    n_checks++;
    shift_word(32'h3333_4444, 33);
    do_load(1'b0);
    if (frame_err !== 1'b1) begin
      $display("FAIL long_frame: got e=%0b expected 1", frame_err);
      n_fail++;
    end
    n_checks++;
    shift_word(32'h1234_5678, 32);
    do_load(1'b0);
    if (frame_err !== 1'b0 || pad_cfg !== 32'h1234_5678) begin
      $display("FAIL recover_frame: got e=%0b cfg=%h expected 0/12345678", frame_err, pad_cfg);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_chain_reset();
    shift_word(32'hDEAD_BEEF, 16);
    shift_rstn = 1'b0;
    wait_clk(5);
    shift_rstn = 1'b1;
    wait_clk(4);
    bench_cnt = 0;
    exp_shift = '0;
    sdo_q.delete();
    if (shift_data_out !== 1'b0) begin
      $display("FAIL chain_rst_sdo: got %0b expected 0", shift_data_out);
      n_fail++;
    end
    n_checks++;
    shift_word(32'h0000_FFFF, 32);
    do_load(1'b0);
    if (pad_cfg !== 32'h0000_FFFF || frame_err !== 1'b0) begin
      $display("FAIL chain_rst_frame: got cfg=%h e=%0b expected 0000ffff/0", pad_cfg, frame_err);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    pad_in = 8'h5A;
    wait_clk(2);
    shift_word(32'hC0DE_F00D, 32);
    do_load(1'b1);
    if (pad_cfg !== 32'hC0DE_F00D || frame_err !== 1'b0) begin
      $display("FAIL simul_edges: got cfg=%h e=%0b expected c0def00d/0", pad_cfg, frame_err);
      n_fail++;
    end
    n_checks++;
    // A dropped extra edge leaves the count at zero, so a fresh frame commits.
    shift_word(32'h0F0F_A5A5, 32);
    do_load(1'b0);
    if (pad_cfg !== 32'h0F0F_A5A5 || frame_err !== 1'b0) begin
      $display("FAIL after_simul: got cfg=%h e=%0b expected 0f0fa5a5/0", pad_cfg, frame_err);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_hard_reset();
    shift_word(32'hFFFF_FFFF, 10);
    #3;
    h_reset_n = 1'b0;
    #1;
    if (pad_cfg !== 32'h0000_0000 || cfg_valid !== 1'b0 || frame_err !== 1'b0 ||
        shift_data_out !== 1'b0) begin
      $display("FAIL async_reset: got cfg=%h v=%0b e=%0b so=%0b expected 0/0/0/0",
               pad_cfg, cfg_valid, frame_err, shift_data_out);
      n_fail++;
    end
    n_checks++;
    wait_clk(2);
    h_reset_n = 1'b1;
    wait_clk(4);
    bench_cnt = 0; exp_shift = '0; exp_cfg = '0;
    exp_valid = 1'b0; exp_err = 1'b0;
    sdo_q.delete();
    shift_word(32'h8001_7FFE, 32);
    do_load(1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_commit();
    test_status_out();
    test_bad_length();
    test_chain_reset();
    test_back_to_back();
    test_hard_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
